// File: rtl/clkgen_prog_pkg.sv
// ----------------------------------------------------------------------------
// clkgen_prog_pkg
// Shared definitions for the DCM_CLKGEN M/D serial programming responder.
// Holds the responder FSM state enum, the load frame length, the command-bit
// values carried in frame bit 1, and the field-to-value helper.
// ----------------------------------------------------------------------------
package clkgen_prog_pkg;

  // Responder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_GAP   = 3'd2,
    ST_GOCHK = 3'd3,
    ST_BUSY  = 3'd4,
    ST_DRAIN = 3'd5
  } prog_state_e;

  // Load frame length in progen_i=1 cycles (start bit + target bit + 8 value bits).
  localparam int FRAME_LEN = 10;

  // Frame bit 1: which staging register the frame targets.
  localparam logic CMD_D = 1'b0;
  localparam logic CMD_M = 1'b1;

  // The frame carries value-1; widen before adding so 255 becomes 256.
  function automatic logic [8:0] field_to_value(input logic [7:0] field);
    return {1'b0, field} + 9'd1;
  endfunction

endpackage

// File: rtl/clkgen_prog_responder.sv
// ----------------------------------------------------------------------------
// clkgen_prog_responder
// Responder end of the DCM_CLKGEN M/D serial programming port; behavioural
// stand-in where the clock primitive is absent.
//
// Optional feature macro: CLKGEN_RESP_CHECK_EN
//   defined   : err_o is a sticky flag for protocol errors and for an M frame
//               with field 0 (M=1), which is then not staged.
//   undefined : err_o is held at 0; malformed frames are still discarded and
//               an M field of 0 is staged as M=1.
//
// Ports
//   clk_usb       in   sole clock, also the programming clock
//   reset_n       in   asynchronous active-low reset
//   progen_i      in   program enable from the loader
//   progdata_i    in   serial program data, sampled while progen_i=1
//   progdone_o    out  1 = idle/complete, 0 = programming in progress
//   mult_o [8:0]  out  applied multiply value M (1-256)
//   div_o  [8:0]  out  applied divide value D (1-256)
//   load_count_o  out  completed GO sequences, wraps 255->0
//   err_o         out  sticky protocol/range error
// ----------------------------------------------------------------------------
module clkgen_prog_responder
  import clkgen_prog_pkg::*;
#(
  parameter int unsigned DONE_LATENCY = 16,
  parameter int unsigned MULT_RESET   = 2,
  parameter int unsigned DIV_RESET    = 2
) (
  input  logic       clk_usb,
  input  logic       reset_n,
  input  logic       progen_i,
  input  logic       progdata_i,
  output logic       progdone_o,
  output logic [8:0] mult_o,
  output logic [8:0] div_o,
  output logic [7:0] load_count_o,
  output logic       err_o
);

  // BUSY is entered with this count and exits on the edge it reaches 0,
  // so BUSY occupies exactly DONE_LATENCY cycles.
  localparam logic [7:0] BUSY_LAST = 8'(DONE_LATENCY - 1);
  localparam logic [7:0] BIT_LAST  = 8'(FRAME_LEN - 1);

  prog_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;          // frame bit index in SHIFT, countdown in BUSY
  logic        target_q, target_d;
  logic [7:0]  field_q, field_d;
  logic [8:0]  stg_mult_q, stg_mult_d;
  logic [8:0]  stg_div_q, stg_div_d;
  logic        has_mult_q, has_mult_d;
  logic        has_div_q, has_div_d;
  logic [8:0]  mult_q, mult_d;
  logic [8:0]  div_q, div_d;
  logic [7:0]  load_count_q, load_count_d;
  logic        err_q, err_d;
  logic        progdone_q, progdone_d;
  logic        err_set;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    field_d      = field_q;
    stg_mult_d   = stg_mult_q;
    stg_div_d    = stg_div_q;
    has_mult_d   = has_mult_q;
    has_div_d    = has_div_q;
    mult_d       = mult_q;
    div_d        = div_q;
    load_count_d = load_count_q;
    err_set      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (progen_i) begin
          if (progdata_i) begin
            state_d = ST_SHIFT;
            cnt_d   = 8'd1;
          end else begin
            state_d = ST_GOCHK;
          end
        end
      end

      ST_SHIFT: begin
        if (progen_i) begin
          if (cnt_q == 8'd1) begin
            target_d = progdata_i;
          end else begin
            // Value bits arrive LSB first; after 8 right shifts the first
            // one sits in bit 0.
            field_d = {progdata_i, field_q[7:1]};
          end
          if (cnt_q == BIT_LAST) begin
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        // The frame is only committed once its closing progen_i=0 is seen;
        // an eleventh enabled cycle makes it malformed and it is dropped.
        if (progen_i) begin
          err_set = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
          if (target_q == CMD_M) begin
`ifdef CLKGEN_RESP_CHECK_EN
            if (field_q == 8'd0) begin
              err_set = 1'b1;
            end else begin
              stg_mult_d = field_to_value(field_q);
              has_mult_d = 1'b1;
            end
`else
            stg_mult_d = field_to_value(field_q);
            has_mult_d = 1'b1;
`endif
          end else begin
            stg_div_d = field_to_value(field_q);
            has_div_d = 1'b1;
          end
        end
      end

      ST_GOCHK: begin
        if (progen_i) begin
          err_set = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_BUSY;
          cnt_d   = BUSY_LAST;
        end
      end

      ST_BUSY: begin
        // progen_i here is ignored apart from the error flag.
        if (progen_i) err_set = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d      = ST_IDLE;
          if (has_mult_q) mult_d = stg_mult_q;
          if (has_div_q)  div_d  = stg_div_q;
          has_mult_d   = 1'b0;
          has_div_d    = 1'b0;
          load_count_d = load_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_DRAIN: begin
        if (!progen_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    progdone_d = !(state_d inside {ST_SHIFT, ST_GAP, ST_GOCHK, ST_BUSY});

`ifdef CLKGEN_RESP_CHECK_EN
    err_d = err_q | err_set;
`else
    // err_q leaves reset at 0 and this AND keeps it there; error events are
    // still decoded above so malformed traffic is discarded identically.
    err_d = err_q & err_set;
`endif
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      target_q     <= CMD_D;
      field_q      <= 8'd0;
      stg_mult_q   <= 9'd0;
      stg_div_q    <= 9'd0;
      has_mult_q   <= 1'b0;
      has_div_q    <= 1'b0;
      mult_q       <= 9'(MULT_RESET);
      div_q        <= 9'(DIV_RESET);
      load_count_q <= 8'd0;
      err_q        <= 1'b0;
      progdone_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      field_q      <= field_d;
      stg_mult_q   <= stg_mult_d;
      stg_div_q    <= stg_div_d;
      has_mult_q   <= has_mult_d;
      has_div_q    <= has_div_d;
      mult_q       <= mult_d;
      div_q        <= div_d;
      load_count_q <= load_count_d;
      err_q        <= err_d;
      progdone_q   <= progdone_d;
    end
  end

  assign progdone_o   = progdone_q;
  assign mult_o       = mult_q;
  assign div_o        = div_q;
  assign load_count_o = load_count_q;
  assign err_o        = err_q;

endmodule
